// File: rtl/radix_chain_counter_pkg.sv
// Shared definitions for the stopwatch counter datapath.
//   DIR_UP / DIR_DOWN : encoding of the dir input
//   DW_DEF            : default bits per digit
//   MMSS_LIMITS       : mm:ss digit limits, digit 0 in the LSBs
//   digit_lim()       : decodes a packed limit field (0 means 2**dw)
package radix_chain_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned DW_DEF   = 4;
  localparam int unsigned NDIG_DEF = 4;

  localparam logic [15:0] MMSS_LIMITS = {4'd6, 4'd10, 4'd6, 4'd10};

  // A zero field stands for the full 2**dw range of the digit.
  function automatic int unsigned digit_lim(input int unsigned field, input int unsigned dw);
    return (field == 0) ? (32'd1 << dw) : field;
  endfunction

endpackage

// File: rtl/radix_chain_counter_digit.sv
// lim_updn_digit: combinational modulo-LIM up/down digit cell.
//   d   : current digit value
//   ci  : carry-in (up) / borrow-in (down)
//   dir : 0 = up, 1 = down
//   q   : next digit value
//   co  : carry-out (up) / borrow-out (down)
module lim_updn_digit
  import radix_chain_counter_pkg::*;
#(
  parameter int unsigned LIM = 10,
  parameter int unsigned DW  = 4
) (
  input  logic [DW-1:0] d,
  input  logic          ci,
  input  logic          dir,
  output logic [DW-1:0] q,
  output logic          co
);

  localparam logic [DW:0]   LIM_W = (DW+1)'(LIM);
  localparam logic [DW-1:0] TOP   = DW'(LIM - 1);

  logic [DW-1:0] eff;

  // Out-of-range values wrap to 0 going up and behave as LIM-1 going down.
  always_comb begin
    q   = d;
    co  = 1'b0;
    eff = ({1'b0, d} >= LIM_W) ? TOP : d;
    if (ci) begin
      if (dir == DIR_UP) begin
        if (d >= TOP) begin
          q  = '0;
          co = 1'b1;
        end else begin
          q = d + DW'(1);
        end
      end else begin
        if (eff == '0) begin
          q  = TOP;
          co = 1'b1;
        end else begin
          q = eff - DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/radix_chain_counter.sv
// radix_chain_counter: cascaded mixed-radix up/down counter.
//   clk, reset (async, active-high)
//   clear    : sync clear to zero (highest sync priority)
//   load     : sync parallel load of load_val, each digit clamped to LIM-1
//   en, dir  : count tick and direction (0 up, 1 down)
//   count    : registered packed digits, digit 0 in LSBs
//   co       : combinational chain overflow/underflow for this tick
//   tc       : combinational terminal count for the current dir
//   sat      : registered hold-at-terminal flag (WRAP=0 only)
module radix_chain_counter
  import radix_chain_counter_pkg::*;
#(
  parameter int unsigned              NDIG   = NDIG_DEF,
  parameter int unsigned              DW     = DW_DEF,
  parameter logic [NDIG*DW-1:0]       LIMITS = MMSS_LIMITS,
  parameter bit                       WRAP   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [NDIG*DW-1:0] load_val,
  output logic [NDIG*DW-1:0] count,
  output logic               co,
  output logic               tc,
  output logic               sat
);

  localparam int unsigned CW = NDIG * DW;

  if (NDIG < 1 || NDIG > 8) begin : g_bad_ndig
    $error("radix_chain_counter: NDIG=%0d out of range 1..8", NDIG);
  end

  logic [NDIG:0]   chain;
  logic [CW-1:0]   step_val;
  logic [CW-1:0]   clamp_val;
  logic [NDIG-1:0] at_top;
  logic [NDIG-1:0] at_zero;
  logic [CW-1:0]   count_nxt;
  logic            sat_nxt;
  logic            hold_term;

  assign chain[0] = 1'b1;

  // One cell per digit, rippling carry/borrow from digit 0 upward.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam int unsigned   LIM = digit_lim(32'(LIMITS[i*DW +: DW]), DW);
    localparam logic [DW-1:0] TOP = DW'(LIM - 1);

    if (LIM < 2 || LIM > (32'd1 << DW)) begin : g_bad_lim
      $error("radix_chain_counter: digit %0d limit %0d out of range", i, LIM);
    end

    lim_updn_digit #(.LIM(LIM), .DW(DW)) u_digit (
      .d   (count[i*DW +: DW]),
      .ci  (chain[i]),
      .dir (dir),
      .q   (step_val[i*DW +: DW]),
      .co  (chain[i+1])
    );

    assign clamp_val[i*DW +: DW] = (load_val[i*DW +: DW] > TOP) ? TOP : load_val[i*DW +: DW];
    assign at_top[i]             = (count[i*DW +: DW] == TOP);
    assign at_zero[i]            = (count[i*DW +: DW] == '0);
  end

  assign tc        = (dir == DIR_DOWN) ? (&at_zero) : (&at_top);
  assign hold_term = !WRAP && tc;
  assign co        = en && !clear && !load && (WRAP ? chain[NDIG] : tc);

  // Priority: clear > load > en step; otherwise hold.
  always_comb begin
    count_nxt = count;
    sat_nxt   = sat;
    if (clear) begin
      count_nxt = '0;
      sat_nxt   = 1'b0;
    end else if (load) begin
      count_nxt = clamp_val;
      sat_nxt   = 1'b0;
    end else if (en) begin
      if (hold_term) begin
        sat_nxt = 1'b1;
      end else begin
        count_nxt = step_val;
        sat_nxt   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_radix_chain_counter.sv
// Self-checking bench: directed mm:ss wrap/hold/priority checks plus a
// random run of a 2-digit (radix 3,10) counter against an integer model.
module tb_radix_chain_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // mm:ss, wrapping
  logic        a_clear, a_en, a_dir, a_load, a_co, a_tc, a_sat;
  logic [15:0] a_load_val, a_count;
  // mm:ss, hold at terminal
  logic        h_clear, h_en, h_dir, h_load, h_co, h_tc, h_sat;
  logic [15:0] h_load_val, h_count;
  // two digits, limits 10 and 3, wrapping
  logic        s_clear, s_en, s_dir, s_load, s_co, s_tc, s_sat;
  logic [7:0]  s_load_val, s_count;

  radix_chain_counter u_wrap (
    .clk(clk), .reset(reset), .clear(a_clear), .en(a_en), .dir(a_dir), .load(a_load),
    .load_val(a_load_val), .count(a_count), .co(a_co), .tc(a_tc), .sat(a_sat));

  radix_chain_counter #(.WRAP(1'b0)) u_hold (
    .clk(clk), .reset(reset), .clear(h_clear), .en(h_en), .dir(h_dir), .load(h_load),
    .load_val(h_load_val), .count(h_count), .co(h_co), .tc(h_tc), .sat(h_sat));

  radix_chain_counter #(.NDIG(2), .DW(4), .LIMITS(8'h3A), .WRAP(1'b1)) u_small (
    .clk(clk), .reset(reset), .clear(s_clear), .en(s_en), .dir(s_dir), .load(s_load),
    .load_val(s_load_val), .count(s_count), .co(s_co), .tc(s_tc), .sat(s_sat));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mixed-radix value -> packed 4-bit digits.
  function automatic int unsigned to_digits(input int unsigned v, input int unsigned nd,
                                            input int unsigned lims[4]);
    int unsigned r = 0;
    for (int i = 0; i < int'(nd); i++) begin
      r |= (v % lims[i]) << (4 * i);
      v  = v / lims[i];
    end
    return r;
  endfunction

  // Packed digits, each clamped to lim-1 -> mixed-radix value.
  function automatic int unsigned clamp_value(input int unsigned lv, input int unsigned nd,
                                              input int unsigned lims[4]);
    int unsigned val = 0;
    int unsigned w   = 1;
    for (int i = 0; i < int'(nd); i++) begin
      int unsigned dg = (lv >> (4 * i)) & 32'hF;
      if (dg > lims[i] - 1) dg = lims[i] - 1;
      val += dg * w;
      w   *= lims[i];
    end
    return val;
  endfunction

  initial begin
    int unsigned small_lims[4];
    int unsigned n_small;
    int unsigned mv;
    int          co_cnt;
    bit          m_clear, m_load, m_en, m_dir, m_tc;
    int unsigned m_lv;

    small_lims = '{10, 3, 1, 1};
    n_small    = 30;

    reset = 1'b1;
    {a_clear, a_en, a_dir, a_load} = '0; a_load_val = '0;
    {h_clear, h_en, h_dir, h_load} = '0; h_load_val = '0;
    {s_clear, s_en, s_dir, s_load} = '0; s_load_val = '0;

    #12;
    check("rst_count", a_count, 0);
    check("rst_sat",   a_sat, 0);
    check("rst_tc",    a_tc, 0);
    check("rst_co",    a_co, 0);
    check("rst_hcount", h_count, 0);
    check("rst_scount", s_count, 0);
    reset = 1'b0;

    // Reset mid-count is immediate.
    a_load = 1; a_load_val = 16'h0537; tick(); a_load = 0;
    check("load_0537", a_count, 16'h0537);
    a_en = 1; tick();
    check("step_0538", a_count, 16'h0538);
    #2 reset = 1'b1; #1;
    check("async_rst_count", a_count, 0);
    check("async_rst_sat",   a_sat, 0);
    reset = 1'b0; a_en = 0;

    // Up cascade and wrap.
    a_load = 1; a_load_val = 16'h0959; tick(); a_load = 0;
    a_en = 1; a_dir = 0; tick();
    check("up_cascade", a_count, 16'h1000);
    a_en = 0; a_load = 1; a_load_val = 16'h5959; tick(); a_load = 0;
    a_en = 1; #1;
    check("up_wrap_co", a_co, 1);
    check("up_wrap_tc", a_tc, 1);
    tick();
    check("up_wrap_count", a_count, 16'h0000);
    check("up_after_co", a_co, 0);
    a_en = 0;

    // Down cascade and wrap.
    a_load = 1; a_load_val = 16'h1000; tick(); a_load = 0;
    a_dir = 1; a_en = 1; tick();
    check("down_cascade", a_count, 16'h0959);
    a_en = 0; a_load = 1; a_load_val = 16'h0000; tick(); a_load = 0;
    a_en = 1; a_dir = 1; #1;
    check("down_wrap_tc", a_tc, 1);
    check("down_wrap_co", a_co, 1);
    tick();
    check("down_wrap_count", a_count, 16'h5959);
    a_en = 0; a_dir = 0;

    // Priority and clamp.
    a_clear = 1; a_load = 1; a_en = 1; a_load_val = 16'h1234; #1;
    check("prio_co_clear", a_co, 0);
    tick();
    check("prio_clear", a_count, 16'h0000);
    a_clear = 0; a_load_val = 16'hF9A9; tick();
    check("clamp_load", a_count, 16'h5959);
    check("load_no_co", a_co, 0);
    a_load = 0; a_en = 0;

    // Hold-at-terminal variant.
    h_load = 1; h_load_val = 16'h5958; tick(); h_load = 0;
    h_en = 1; h_dir = 0; tick();
    check("hold_5959", h_count, 16'h5959);
    check("hold_sat0", h_sat, 0);
    check("hold_tc", h_tc, 1);
    check("hold_co", h_co, 1);
    tick();
    check("hold_stay", h_count, 16'h5959);
    check("hold_sat1", h_sat, 1);
    check("hold_co_held", h_co, 1);
    h_dir = 1; #1;
    check("hold_rev_co", h_co, 0);
    tick();
    check("hold_rev_count", h_count, 16'h5958);
    check("hold_rev_sat", h_sat, 0);
    h_en = 0; h_clear = 1; tick(); h_clear = 0;
    check("hold_clear", h_count, 16'h0000);
    h_en = 1; h_dir = 1; tick();
    check("hold_down_count", h_count, 16'h0000);
    check("hold_down_sat", h_sat, 1);
    h_en = 0; h_load = 1; h_load_val = 16'h0100; tick(); h_load = 0;
    check("hold_load_sat", h_sat, 0);
    check("hold_load_val", h_count, 16'h0100);

    // Two-digit sweep: 30 up steps return to 00 with a single co.
    co_cnt = 0;
    s_en = 1; s_dir = 0;
    for (int k = 0; k < 30; k++) begin
      if (s_co) co_cnt++;
      tick();
    end
    check("sweep_count", s_count, 0);
    check("sweep_co_pulses", co_cnt, 1);
    s_en = 0;

    // Random run against the integer model.
    mv = 0;
    for (int k = 0; k < 10000; k++) begin
      m_clear = ($urandom_range(15) == 0);
      m_load  = ($urandom_range(7) == 0);
      m_en    = ($urandom_range(3) != 0);
      m_dir   = $urandom_range(1) == 1;
      m_lv    = $urandom_range(255);
      s_clear = m_clear; s_load = m_load; s_en = m_en; s_dir = m_dir;
      s_load_val = 8'(m_lv);
      #1;
      m_tc = m_dir ? (mv == 0) : (mv == n_small - 1);
      check("rnd_tc", s_tc, 32'(m_tc));
      check("rnd_co", s_co, 32'(m_en && !m_clear && !m_load && m_tc));
      tick();
      if (m_clear)     mv = 0;
      else if (m_load) mv = clamp_value(m_lv, 2, small_lims);
      else if (m_en)   mv = m_dir ? (mv + n_small - 1) % n_small : (mv + 1) % n_small;
      check("rnd_count", s_count, to_digits(mv, 2, small_lims));
      check("rnd_sat", s_sat, 0);
    end
    {s_clear, s_en, s_dir, s_load} = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
